// File: rtl/fetch_mem_unit.sv
// Fetch/memory stage: PC, IR and MDR registers around a unified single-port
// word memory with a fixed number of wait states per access.
module fetch_mem_unit #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 10,
    parameter int                MEM_LAT  = 2,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              input_PC_PCWrite,
    input  logic [DATA_W-1:0] input_PC_newPC,
    input  logic              input_PC_inc,
    output logic [DATA_W-1:0] output_PC,
    input  logic              input_mem_req,
    input  logic              IorD,
    input  logic [DATA_W-1:0] input_from_ALUOut,
    input  logic              input_mem_write,
    input  logic [DATA_W-1:0] input_mem_data,
    input  logic              input_IR_write,
    output logic              output_mem_ready,
    output logic              output_busy,
    output logic              output_addr_fault,
    output logic [DATA_W-1:0] output_MDR,
    output logic [DATA_W-1:0] output_IR,
    output logic [3:0]        Output_IR_Control,
    output logic [3:0]        Output_IR_RegD,
    output logic [3:0]        Output_IR_RegA,
    output logic [3:0]        Output_IR_RegB,
    output logic [DATA_W-1:0] Output_IR_Imm
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              irw_q, irw_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] mdr_q;

    logic [DATA_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_idx;
    logic              req_oob;
    logic              access_fire;
    logic              mem_we;
    logic              mem_re;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign req_addr = IorD ? input_from_ALUOut : pc_q;

    // Any address bit above the memory depth marks the access as out of range.
    generate
        if (ADDR_W < DATA_W) begin : g_range
            assign req_oob = |req_addr[DATA_W-1:ADDR_W];
            assign req_idx = req_addr[ADDR_W-1:0];
        end else begin : g_full
            assign req_oob = 1'b0;
            assign req_idx = ADDR_W'(req_addr);
        end
    endgenerate

    // PC update runs every cycle, independently of the access FSM.
    always_comb begin
        pc_d = pc_q;
        if (input_PC_PCWrite) begin
            pc_d = input_PC_newPC;
        end else if (input_PC_inc) begin
            pc_d = pc_q + DATA_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        irw_d   = irw_q;
        wdata_d = wdata_q;
        fault_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (input_mem_req) begin
                    if (req_oob) begin
                        fault_d = 1'b1;
                    end else begin
                        addr_d  = req_idx;
                        wr_d    = input_mem_write;
                        irw_d   = input_IR_write;
                        wdata_d = input_mem_data;
                        cnt_d   = LAT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            irw_q   <= 1'b0;
            wdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            irw_q   <= irw_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
        end
    end

    // The access happens on the edge that leaves WAIT; reset on that edge aborts it.
    assign access_fire = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign mem_we      = access_fire && wr_q && !Reset;
    assign mem_re      = access_fire && !wr_q;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            mdr_q <= '0;
            ir_q  <= '0;
        end else if (mem_re) begin
            mdr_q <= mem[addr_q];
            if (irw_q) begin
                ir_q <= mem[addr_q];
            end
        end
    end

    assign output_PC         = pc_q;
    assign output_MDR        = mdr_q;
    assign output_IR         = ir_q;
    assign output_busy       = (state_q == ST_WAIT);
    assign output_mem_ready  = (state_q == ST_DONE);
    assign output_addr_fault = fault_q;

    assign Output_IR_Control = ir_q[DATA_W-1 -: 4];
    assign Output_IR_RegD    = ir_q[DATA_W-5 -: 4];
    assign Output_IR_RegA    = ir_q[7:4];
    assign Output_IR_RegB    = ir_q[3:0];
    assign Output_IR_Imm     = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Bench for fetch_mem_unit: table of accesses plus hand-built sequences for
// busy-ignore, back-to-back, PC priority/wrap, reset abort and zero latency.
module tb_fetch_mem_unit;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcwrite = 1'b0;
    logic [15:0] newpc = '0;
    logic        pcinc = 1'b0;
    logic        req = 1'b0;
    logic        req0 = 1'b0;
    logic        iord = 1'b0;
    logic [15:0] alu = '0;
    logic        wr = 1'b0;
    logic [15:0] wdata = '0;
    logic        irw = 1'b0;

    logic [15:0] pc, mdr, ir, imm;
    logic [3:0]  f_ctl, f_rd, f_ra, f_rb;
    logic        ready, busy, fault;

    logic [15:0] pc0, mdr0, ir0, imm0;
    logic [3:0]  g_ctl, g_rd, g_ra, g_rb;
    logic        ready0, busy0, fault0;

    always #5 clk = ~clk;

    fetch_mem_unit #(.DATA_W(16), .ADDR_W(10), .MEM_LAT(LAT), .RESET_PC(16'h0000)) dut (
        .CLK(clk), .Reset(rst),
        .input_PC_PCWrite(pcwrite), .input_PC_newPC(newpc), .input_PC_inc(pcinc),
        .output_PC(pc),
        .input_mem_req(req), .IorD(iord), .input_from_ALUOut(alu),
        .input_mem_write(wr), .input_mem_data(wdata), .input_IR_write(irw),
        .output_mem_ready(ready), .output_busy(busy), .output_addr_fault(fault),
        .output_MDR(mdr), .output_IR(ir),
        .Output_IR_Control(f_ctl), .Output_IR_RegD(f_rd), .Output_IR_RegA(f_ra),
        .Output_IR_RegB(f_rb), .Output_IR_Imm(imm)
    );

    fetch_mem_unit #(.DATA_W(16), .ADDR_W(10), .MEM_LAT(0), .RESET_PC(16'h0000)) dut0 (
        .CLK(clk), .Reset(rst),
        .input_PC_PCWrite(pcwrite), .input_PC_newPC(newpc), .input_PC_inc(pcinc),
        .output_PC(pc0),
        .input_mem_req(req0), .IorD(iord), .input_from_ALUOut(alu),
        .input_mem_write(wr), .input_mem_data(wdata), .input_IR_write(irw),
        .output_mem_ready(ready0), .output_busy(busy0), .output_addr_fault(fault0),
        .output_MDR(mdr0), .output_IR(ir0),
        .Output_IR_Control(g_ctl), .Output_IR_RegD(g_rd), .Output_IR_RegA(g_ra),
        .Output_IR_RegB(g_rb), .Output_IR_Imm(imm0)
    );

    typedef struct {
        logic        wr;
        logic        iord;
        logic [15:0] addr;
        logic [15:0] data;
        logic        irw;
        logic        fault;
        logic [15:0] mdr;
        logic [15:0] ir;
    } vec_t;

    typedef struct {
        logic [15:0] mdr;
        logic [15:0] ir;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ready_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and sample; completed accesses are scored here.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (ready) begin
            ready_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready: got ready=1 at cycle %0d expected no access pending", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("ready_mdr", mdr, e.mdr);
                chk("ready_ir", ir, e.ir);
                chk("ready_cycle", cyc, e.due);
            end
        end
    endtask

    task automatic wait_drain(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            if (busy) busy_cycles++;
            tick();
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic chk_fields(input logic [15:0] e);
        chk("ir_ctl", f_ctl, e[15:12]);
        chk("ir_regd", f_rd, e[11:8]);
        chk("ir_rega", f_ra, e[7:4]);
        chk("ir_regb", f_rb, e[3:0]);
        chk("ir_imm", imm, {{8{e[7]}}, e[7:0]});
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int bc;
        if (!v.iord) begin
            pcwrite = 1'b1;
            newpc   = v.addr;
            tick();
            pcwrite = 1'b0;
            alu     = 16'hFFFF;
        end else begin
            alu = v.addr;
        end
        iord  = v.iord;
        wr    = v.wr;
        wdata = v.data;
        irw   = v.irw;
        req   = 1'b1;
        tick();
        req = 1'b0;
        if (v.fault) begin
            chk("fault_pulse", fault, 1'b1);
            chk("fault_busy", busy, 1'b0);
            tick();
            chk("fault_clear", fault, 1'b0);
            chk("fault_ready", ready, 1'b0);
        end else begin
            chk("no_fault", fault, 1'b0);
            sb_q.push_back('{mdr: v.mdr, ir: v.ir, due: cyc + LAT + 1});
            wait_drain(bc);
            chk("busy_cycles", bc, LAT + 1);
        end
        chk("vec_mdr", mdr, v.mdr);
        chk("vec_ir", ir, v.ir);
        chk_fields(v.ir);
        $display("vec %0d: wr=%0b iord=%0b addr=%h data=%h irw=%0b -> mdr=%h ir=%h fault_exp=%0b",
                 idx, v.wr, v.iord, v.addr, v.data, v.irw, mdr, ir, v.fault);
    endtask

    initial begin
        int bc;
        int r0;
        int n;

        vecs[0] = '{1'b1, 1'b1, 16'h0010, 16'h5A9C, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h5A9C, 16'h5A9C};
        vecs[2] = '{1'b1, 1'b1, 16'h03FF, 16'h1234, 1'b1, 1'b0, 16'h5A9C, 16'h5A9C};
        vecs[3] = '{1'b1, 1'b1, 16'h0000, 16'h0F0F, 1'b0, 1'b0, 16'h5A9C, 16'h5A9C};
        vecs[4] = '{1'b1, 1'b1, 16'h0400, 16'hDEAD, 1'b0, 1'b1, 16'h5A9C, 16'h5A9C};
        vecs[5] = '{1'b0, 1'b1, 16'h03FF, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h5A9C};
        vecs[6] = '{1'b0, 1'b1, 16'h8000, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'h5A9C};
        vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0F0F, 16'h0F0F};
        vecs[8] = '{1'b0, 1'b0, 16'h0400, 16'h0000, 1'b1, 1'b1, 16'h0F0F, 16'h0F0F};
        vecs[9] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h5A9C, 16'h0F0F};

        rst = 1'b1;
        tick();
        tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_mdr", mdr, 16'h0000);
        chk("rst_ready", ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fault", fault, 1'b0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Requests during WAIT are ignored; operands are captured at acceptance.
        r0 = ready_cnt;
        iord = 1'b1; alu = 16'h0030; wr = 1'b1; wdata = 16'h7777; irw = 1'b0; req = 1'b1;
        tick();
        sb_q.push_back('{mdr: 16'h5A9C, ir: 16'h0F0F, due: cyc + LAT + 1});
        alu = 16'h0031; wdata = 16'h1111;
        tick();
        tick();
        req = 1'b0;
        wait_drain(bc);
        for (int i = 0; i < 4; i++) tick();
        chk("ignore_one_ready", ready_cnt - r0, 1);
        $display("busy-ignore: ready pulses=%0d", ready_cnt - r0);
        run_vec(10, '{1'b0, 1'b1, 16'h0030, 16'h0000, 1'b0, 1'b0, 16'h7777, 16'h0F0F});

        // Held request is re-accepted in DONE: one access every LAT+2 cycles.
        iord = 1'b1; alu = 16'h0010; wr = 1'b0; irw = 1'b1; req = 1'b1;
        tick();
        sb_q.push_back('{mdr: 16'h5A9C, ir: 16'h5A9C, due: cyc + LAT + 1});
        for (int i = 0; i < LAT + 1; i++) tick();
        chk("b2b_first_ready", ready, 1'b1);
        alu = 16'h0030;
        tick();
        req = 1'b0;
        sb_q.push_back('{mdr: 16'h7777, ir: 16'h7777, due: cyc + LAT + 1});
        wait_drain(bc);
        chk("b2b_mdr", mdr, 16'h7777);
        $display("back-to-back: mdr=%h ir=%h", mdr, ir);

        // PC priority and wrap.
        pcwrite = 1'b1; newpc = 16'h1234; pcinc = 1'b1;
        tick();
        chk("pc_priority", pc, 16'h1234);
        newpc = 16'hFFFF; pcinc = 1'b0;
        tick();
        pcwrite = 1'b0; pcinc = 1'b1;
        tick();
        chk("pc_wrap", pc, 16'h0000);
        tick();
        pcinc = 1'b0;
        chk("pc_inc", pc, 16'h0001);
        $display("pc: final=%h", pc);

        // Reset on the access edge must abort the write and the ready pulse.
        run_vec(11, '{1'b1, 1'b1, 16'h0020, 16'h0BAD, 1'b0, 1'b0, 16'h7777, 16'h7777});
        iord = 1'b1; alu = 16'h0020; wr = 1'b1; wdata = 16'hBEEF; irw = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        chk("abort_busy", busy, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r0 = ready_cnt;
        chk("abort_busy_clear", busy, 1'b0);
        chk("abort_mdr_rst", mdr, 16'h0000);
        for (int i = 0; i < 5; i++) tick();
        chk("abort_no_ready", ready_cnt - r0, 0);
        $display("reset-abort: ready pulses after reset=%0d", ready_cnt - r0);
        run_vec(12, '{1'b0, 1'b1, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0BAD, 16'h0BAD});

        // Zero wait states: ready one edge after the accepting edge.
        iord = 1'b1; alu = 16'h0040; wr = 1'b1; wdata = 16'h4242; irw = 1'b0; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        chk("lat0_busy", busy0, 1'b1);
        n = 0;
        while (!ready0 && n < 10) begin tick(); n++; end
        chk("lat0_write_latency", n, 1);
        wr = 1'b0; irw = 1'b1; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        n = 0;
        while (!ready0 && n < 10) begin tick(); n++; end
        chk("lat0_read_latency", n, 1);
        chk("lat0_mdr", mdr0, 16'h4242);
        chk("lat0_ir", ir0, 16'h4242);
        $display("lat0: latency=%0d mdr=%h ir=%h", n, mdr0, ir0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
